// File: rtl/alu_pkg.sv
// Shared types for the ALU operation issuer: opcodes, FSM states and the
// illegal-opcode test.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_RESP
    } state_e;

    // Every opcode with the top bit set is reserved.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding {use_acc, opcode, a, b}; DEPTH must be a power of two
// so the pointers wrap naturally.
module alu_cmd_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [2*N+3:0]   data_i,
    input  logic             pop_i,
    output logic [2*N+3:0]   data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [2*N+3:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           push_ok;
    logic           pop_ok;

    // Count tops out at DEPTH == 2**AW, so its MSB alone flags full.
    assign full_o  = count_q[AW];
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Buffers ALU commands, drives registered operands to an external ALU and
// returns one held response per command, keeping a result accumulator.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_opcode,
    input  logic [N-1:0] cmd_a,
    input  logic [N-1:0] cmd_b,
    input  logic         cmd_use_acc,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_opcode,
    input  logic [N-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_err,
    output logic [N-1:0] acc
);
    localparam int W = 2 * N + 4;

    state_e       state_q;
    logic [W-1:0] fifo_wdata;
    logic [W-1:0] head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         head_use_acc;
    logic [2:0]   head_op;
    logic [N-1:0] head_a;
    logic [N-1:0] head_b;
    logic [N-1:0] alu_a_q;
    logic [N-1:0] alu_b_q;
    logic [2:0]   alu_op_q;
    logic         err_q;
    logic         rsp_valid_q;
    logic [N-1:0] rsp_result_q;
    logic         rsp_err_q;
    logic [N-1:0] acc_q;
    logic [N-1:0] result_d;

    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign pop        = (state_q == S_LOAD);
    assign fifo_wdata = {cmd_use_acc, cmd_opcode, cmd_a, cmd_b};

    alu_cmd_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (fifo_wdata),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_use_acc = head[W-1];
    assign head_op      = head[W-2 -: 3];
    assign head_a       = head[2*N-1 -: N];
    assign head_b       = head[N-1:0];

    // Illegal commands return all-ones and leave the accumulator alone.
    assign result_d = err_q ? {N{1'b1}} : alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= 3'b000;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            acc_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    alu_a_q  <= head_use_acc ? acc_q : head_a;
                    alu_b_q  <= head_b;
                    alu_op_q <= head_op;
                    err_q    <= is_illegal_op(head_op);
                    state_q  <= S_EXEC;
                end
                S_EXEC: begin
                    rsp_result_q <= result_d;
                    rsp_err_q    <= err_q;
                    rsp_valid_q  <= 1'b1;
                    if (!err_q) begin
                        acc_q <= result_d;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= fifo_empty ? S_IDLE : S_LOAD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign acc        = acc_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer: directed commands push hand-computed
// responses into a queue, a monitor pops and checks them at each handshake.
module tb_alu_op_issuer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_opcode = 3'b000;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic       cmd_use_acc = 1'b0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_result;
    logic       rsp_err;
    logic [7:0] acc;

    typedef struct packed {
        logic [7:0] res;
        logic       err;
        logic [7:0] acc;
    } exp_t;

    exp_t exp_q[$];
    int   cmp = 0;
    int   mism = 0;
    int   ready_ctl = 1;   // 0 = hold low, 1 = hold high, 2 = random
    logic held = 1'b0;
    logic [7:0] held_res;
    logic       held_err;

    alu_op_issuer #(.N(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_err     (rsp_err),
        .acc         (acc)
    );

    always #5 clk = ~clk;

    // Combinational ALU behind the issuer.
    always_comb begin
        case (alu_opcode)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            default: alu_result = 8'h5A;
        endcase
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        cmp++;
        if (act !== req) begin
            mism++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_ctl == 2) rsp_ready = 1'($urandom_range(0, 1));
            else rsp_ready = (ready_ctl == 1);
        end
    end

    // Monitor: stability while stalled, scoreboard compare at each transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else if (rsp_valid) begin
            if (held) begin
                chk("rsp_result_stable", rsp_result, held_res);
                chk("rsp_err_stable", {7'd0, rsp_err}, {7'd0, held_err});
            end
            if (rsp_ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    cmp++;
                    mism++;
                    $display("FAIL unexpected_rsp: got result %h err %b, expected none", rsp_result, rsp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_result", rsp_result, e.res);
                    chk("rsp_err", {7'd0, rsp_err}, {7'd0, e.err});
                    chk("acc", acc, e.acc);
                end
            end else begin
                held     = 1'b1;
                held_res = rsp_result;
                held_err = rsp_err;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ua, input logic [7:0] eres, input logic eerr,
                        input logic [7:0] eacc);
        int n;
        exp_t e;
        @(negedge clk);
        cmd_opcode  = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        cmd_valid   = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            cmp++;
            mism++;
            $display("FAIL send_timeout: cmd_ready %b, expected 1", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            e.res = eres;
            e.err = eerr;
            e.acc = eacc;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 400) begin
            @(posedge clk);
            n++;
        end
        cmp++;
        if (exp_q.size() != 0) begin
            mism++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        repeat (10) @(posedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"}, {7'd0, cmd_ready}, 8'h01);
        chk({tag, "_rsp_valid"}, {7'd0, rsp_valid}, 8'h00);
        chk({tag, "_rsp_result"}, rsp_result, 8'h00);
        chk({tag, "_rsp_err"}, {7'd0, rsp_err}, 8'h00);
        chk({tag, "_acc"}, acc, 8'h00);
        chk({tag, "_alu_a"}, alu_a, 8'h00);
        chk({tag, "_alu_b"}, alu_b, 8'h00);
        chk({tag, "_alu_opcode"}, {5'd0, alu_opcode}, 8'h00);
    endtask

    initial begin
        logic seen;
        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: accepted at edge t, rsp_valid only after edge t+3.
        send(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 8'h80);
        chk("lat_t0", {7'd0, rsp_valid}, 8'h00);
        @(posedge clk); #1;
        chk("lat_t1", {7'd0, rsp_valid}, 8'h00);
        @(posedge clk); #1;
        chk("lat_t2", {7'd0, rsp_valid}, 8'h00);
        @(posedge clk); #1;
        chk("lat_t3", {7'd0, rsp_valid}, 8'h01);
        drain();

        // Accumulator chaining back-to-back.
        send(OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 8'hFF);
        send(OP_XOR, 8'h55, 8'hF0, 1'b1, 8'h0F, 1'b0, 8'h0F);
        drain();

        // Illegal opcode keeps the accumulator.
        send(3'b101, 8'h12, 8'h34, 1'b0, 8'hFF, 1'b1, 8'h0F);
        drain();
        chk("acc_after_illegal", acc, 8'h0F);

        // Backpressure: fill the FIFO behind a stalled response.
        ready_ctl = 0;
        @(posedge clk); #2;
        send(OP_ADD, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 8'h03);
        send(OP_SUB, 8'h10, 8'h03, 1'b0, 8'h0D, 1'b0, 8'h0D);
        send(OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 8'h30);
        send(OP_XOR, 8'h00, 8'h0F, 1'b1, 8'h3F, 1'b0, 8'h3F);
        send(OP_ADD, 8'h00, 8'h01, 1'b1, 8'h40, 1'b0, 8'h40);
        repeat (3) @(posedge clk);
        #1;
        chk("full_cmd_ready", {7'd0, cmd_ready}, 8'h00);
        @(negedge clk);
        cmd_opcode = OP_ADD;
        cmd_a      = 8'hEE;
        cmd_b      = 8'hEE;
        cmd_valid  = 1'b1;
        repeat (3) @(negedge clk);
        chk("full_ignored_push", {7'd0, cmd_ready}, 8'h00);
        cmd_valid = 1'b0;
        ready_ctl = 1;
        drain();

        // Reset while a command is in EXEC and two more are queued.
        send(OP_ADD, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 8'h33);
        send(OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 8'h02);
        send(OP_ADD, 8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 8'h04);
        chk("pre_reset_alu_a", alu_a, 8'h11);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("no_rsp_after_reset", {7'd0, seen}, 8'h00);

        // Random consumer backpressure over a dependent command chain.
        ready_ctl = 2;
        send(OP_ADD, 8'h20, 8'h22, 1'b0, 8'h42, 1'b0, 8'h42);
        send(OP_SUB, 8'h00, 8'h50, 1'b1, 8'hF2, 1'b0, 8'hF2);
        send(OP_AND, 8'h00, 8'h0F, 1'b1, 8'h02, 1'b0, 8'h02);
        send(3'b111, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 8'h02);
        send(OP_XOR, 8'h00, 8'hFF, 1'b1, 8'hFD, 1'b0, 8'hFD);
        send(OP_ADD, 8'h00, 8'h05, 1'b1, 8'h02, 1'b0, 8'h02);
        send(OP_SUB, 8'h05, 8'h0A, 1'b0, 8'hFB, 1'b0, 8'hFB);
        send(OP_AND, 8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00);
        ready_ctl = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule

// File: doc/alu_op_issuer.md
ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

Interface
REQ-001 Parameter N, default 8, operand/result width in bits.
REQ-002 Parameter DEPTH, default 4, command FIFO depth (power of 2, >=2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO not full; transfer when cmd_valid && cmd_ready.
REQ-007 cmd_opcode  input  3  000 add, 001 sub, 010 and, 011 xor, 100-111 illegal.
REQ-008 cmd_a, cmd_b  input  N  operands.
REQ-009 cmd_use_acc  input  1  1: use accumulator instead of cmd_a as operand A.
REQ-010 alu_a, alu_b  output  N  registered operands to the ALU.
REQ-011 alu_opcode  output  3  registered opcode to the ALU.
REQ-012 alu_result  input  N  combinational ALU result for alu_a/alu_b/alu_opcode.
REQ-013 rsp_valid  output  1  response held.
REQ-014 rsp_ready  input  1  consumer accepts; transfer when rsp_valid && rsp_ready.
REQ-015 rsp_result  output  N  captured result.
REQ-016 rsp_err  output  1  command had an illegal opcode.
REQ-017 acc  output  N  accumulator value.

Function
REQ-018 FSM states IDLE, LOAD, EXEC, RESP; exactly one active.
REQ-019 IDLE -> LOAD when FIFO non-empty; else stay.
REQ-020 LOAD (1 cycle): pop FIFO head; register alu_a = use_acc ? acc : a, alu_b, alu_opcode, err = (opcode[2]==1); -> EXEC.
REQ-021 EXEC (1 cycle): capture rsp_result = err ? {N{1'b1}} : alu_result, rsp_err = err; acc updated to same value only when err==0; set rsp_valid; -> RESP.
REQ-022 RESP: hold rsp_* stable while rsp_ready==0; on rsp_ready, clear rsp_valid, -> LOAD if FIFO non-empty (post-pop count) else IDLE.
REQ-023 Latency: command written into empty FIFO at edge t reaches LOAD at t+1 (IDLE), rsp_valid at t+3; min 3 cycles/command.
REQ-024 alu_* outputs hold last loaded values outside LOAD; no change in EXEC/RESP.
REQ-025 cmd_use_acc commands see acc including result of immediately preceding command (acc updated in EXEC before next LOAD).
REQ-026 Arithmetic is modulo 2^N; no carry/borrow output.
REQ-027 cmd_ready = !full; simultaneous push and pop on a full FIFO not permitted (cmd_ready low), on non-full FIFO both occur.
REQ-028 FIFO pointers wrap modulo DEPTH; order strictly preserved.
REQ-029 Push with cmd_valid while cmd_ready==0 ignored; FIFO contents unchanged.

Reset
REQ-030 rst_n low asynchronously: state IDLE, FIFO empty, cmd_ready 1, rsp_valid 0, rsp_result 0, rsp_err 0, acc 0, alu_a 0, alu_b 0, alu_opcode 000.
REQ-031 Reset mid-operation discards FIFO contents and any pending response; no response emitted for them.
REQ-032 First command accepted on first rising edge with rst_n high.

Structure
REQ-033 Shared package alu_pkg holds opcode typedef (ADD, SUB, AND, XOR), illegal-opcode test function, FSM state typedef.
REQ-034 FIFO in sub-module alu_cmd_fifo (parameters N, DEPTH; push/pop/full/empty), storing {use_acc, opcode, a, b}.

Verification
REQ-035 N=8: cmd add a=8'h7F b=8'h01 -> rsp_valid 3 cycles after acceptance, rsp_result 8'h80, rsp_err 0, acc 8'h80.
REQ-036 sub a=8'h00 b=8'h01 then use_acc xor b=8'hF0 -> results 8'hFF then 8'h0F, acc 8'h0F.
REQ-037 opcode 3'b101 a=8'h12 -> rsp_result 8'hFF, rsp_err 1, acc unchanged.
REQ-038 Hold rsp_ready=0, push 5 commands -> cmd_ready low after FIFO full (4 queued); release -> 5 responses in order, none lost.
REQ-039 Assert rst_n low during EXEC with 2 queued -> all outputs at reset values immediately, no responses after release.
REQ-040 Random commands vs reference model, DEPTH=4, random rsp_ready -> ordered, correct, rsp_* stable while stalled.
